// File: rtl/chisel_top.sv
// Lab-board integration: PS/2 key decoder with seven-segment key display,
// 640x480@60 VGA colour-bar generator, and switch-to-LED mirror.
module chisel_top (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] io_sw,
  input  logic        io_ps2_clk,
  input  logic        io_ps2_data,
  output logic [15:0] io_ledr,
  output logic        io_VGA_CLK,
  output logic        io_VGA_HSYNC,
  output logic        io_VGA_VSYNC,
  output logic        io_VGA_BLANK_N,
  output logic [7:0]  io_VGA_R,
  output logic [7:0]  io_VGA_G,
  output logic [7:0]  io_VGA_B,
  output logic [7:0]  io_seg0,
  output logic [7:0]  io_seg1,
  output logic [7:0]  io_seg2,
  output logic [7:0]  io_seg3,
  output logic [7:0]  io_seg4,
  output logic [7:0]  io_seg5,
  output logic [7:0]  io_seg6,
  output logic [7:0]  io_seg7
);

  assign io_ledr    = io_sw;
  assign io_VGA_CLK = clock;

  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic [9:0] w_h;
  logic [2:0] w_bar;
  logic       w_vis;
  logic [7:0] w_inv;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == 10'd799) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == 10'd524) ? 10'd0 : r_vcnt + 10'd1;
    end else begin
      r_hcnt <= r_hcnt + 10'd1;
    end
  end

  assign w_vis = (r_hcnt >= 10'd144) && (r_hcnt < 10'd784) &&
                 (r_vcnt >= 10'd35)  && (r_vcnt < 10'd515);
  assign w_h   = r_hcnt - 10'd144;

  // Bar index h/80 as a compare ladder instead of a divider.
  always_comb begin
    w_bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (w_h >= 10'(i * 80)) w_bar = 3'(i);
    end
  end

  assign w_inv          = {8{io_sw[0]}};
  assign io_VGA_HSYNC   = (r_hcnt >= 10'd96);
  assign io_VGA_VSYNC   = (r_vcnt >= 10'd2);
  assign io_VGA_BLANK_N = w_vis;
  assign io_VGA_R       = w_vis ? ({8{w_bar[2]}} ^ w_inv) : 8'h00;
  assign io_VGA_G       = w_vis ? ({8{w_bar[1]}} ^ w_inv) : 8'h00;
  assign io_VGA_B       = w_vis ? ({8{w_bar[0]}} ^ w_inv) : 8'h00;

  logic [2:0] r_ps2c;
  logic [1:0] r_ps2d;
  logic [9:0] r_buf;
  logic [3:0] r_bitcnt;
  logic       r_rx_stb;
  logic [7:0] r_rx_byte;
  logic       w_fall;
  logic       w_frame_ok;

  assign w_fall = r_ps2c[2] & ~r_ps2c[1];
  // r_buf holds {parity, data[7:0], start}; the live data bit is the stop bit.
  assign w_frame_ok = ~r_buf[0] & r_ps2d[1] & (^r_buf[9:1]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ps2c    <= 3'b111;
      r_ps2d    <= 2'b11;
      r_buf     <= '0;
      r_bitcnt  <= '0;
      r_rx_stb  <= 1'b0;
      r_rx_byte <= '0;
    end else begin
      r_ps2c   <= {r_ps2c[1:0], io_ps2_clk};
      r_ps2d   <= {r_ps2d[0], io_ps2_data};
      r_rx_stb <= 1'b0;
      if (w_fall) begin
        if (r_bitcnt == 4'd10) begin
          r_bitcnt <= '0;
          if (w_frame_ok) begin
            r_rx_stb  <= 1'b1;
            r_rx_byte <= r_buf[8:1];
          end
        end else begin
          r_buf    <= {r_ps2d[1], r_buf[9:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end
    end
  end

  logic       r_brk;
  logic       r_held;
  logic [7:0] r_code;
  logic [7:0] r_last;
  logic       r_lastv;
  logic [3:0] r_tens;
  logic [3:0] r_units;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_brk   <= 1'b0;
      r_held  <= 1'b0;
      r_code  <= '0;
      r_last  <= '0;
      r_lastv <= 1'b0;
      r_tens  <= '0;
      r_units <= '0;
    end else if (r_rx_stb) begin
      r_last  <= r_rx_byte;
      r_lastv <= 1'b1;
      if (r_rx_byte == 8'hE0) begin
        r_brk <= r_brk;
      end else if (r_rx_byte == 8'hF0) begin
        r_brk <= 1'b1;
      end else if (r_brk) begin
        r_brk  <= 1'b0;
        r_held <= 1'b0;
      end else if (!r_held || (r_code != r_rx_byte)) begin
        // New key down; typematic repeats of the held key fall through.
        r_code <= r_rx_byte;
        r_held <= 1'b1;
        if (r_units == 4'd9) begin
          r_units <= 4'd0;
          r_tens  <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
        end else begin
          r_units <= r_units + 4'd1;
        end
      end
    end
  end

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    case (d)
      4'h0: f_seg = 8'hC0;
      4'h1: f_seg = 8'hF9;
      4'h2: f_seg = 8'hA4;
      4'h3: f_seg = 8'hB0;
      4'h4: f_seg = 8'h99;
      4'h5: f_seg = 8'h92;
      4'h6: f_seg = 8'h82;
      4'h7: f_seg = 8'hF8;
      4'h8: f_seg = 8'h80;
      4'h9: f_seg = 8'h90;
      4'hA: f_seg = 8'h88;
      4'hB: f_seg = 8'h83;
      4'hC: f_seg = 8'hC6;
      4'hD: f_seg = 8'hA1;
      4'hE: f_seg = 8'h86;
      default: f_seg = 8'h8E;
    endcase
  endfunction

  assign io_seg0 = r_held  ? f_seg(r_code[3:0]) : 8'hFF;
  assign io_seg1 = r_held  ? f_seg(r_code[7:4]) : 8'hFF;
  assign io_seg2 = r_lastv ? f_seg(r_last[3:0]) : 8'hFF;
  assign io_seg3 = r_lastv ? f_seg(r_last[7:4]) : 8'hFF;
  assign io_seg4 = f_seg(r_units);
  assign io_seg5 = f_seg(r_tens);
  assign io_seg6 = 8'hFF;
  assign io_seg7 = 8'hFF;

endmodule

// File: tb/tb_chisel_top.sv
// Bench for chisel_top: random PS/2 frames scored against a key-tracker model,
// plus a per-cycle VGA/LED check derived from the elapsed cycle count.
module tb_chisel_top;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] io_sw = 16'h0000;
  logic        ps2c = 1'b1;
  logic        ps2d = 1'b1;
  logic [15:0] io_ledr;
  logic        io_VGA_CLK, io_VGA_HSYNC, io_VGA_VSYNC, io_VGA_BLANK_N;
  logic [7:0]  io_VGA_R, io_VGA_G, io_VGA_B;
  logic [7:0]  io_seg0, io_seg1, io_seg2, io_seg3;
  logic [7:0]  io_seg4, io_seg5, io_seg6, io_seg7;

  chisel_top dut (
    .clock(clock), .resetn(resetn), .io_sw(io_sw),
    .io_ps2_clk(ps2c), .io_ps2_data(ps2d),
    .io_ledr(io_ledr), .io_VGA_CLK(io_VGA_CLK),
    .io_VGA_HSYNC(io_VGA_HSYNC), .io_VGA_VSYNC(io_VGA_VSYNC),
    .io_VGA_BLANK_N(io_VGA_BLANK_N),
    .io_VGA_R(io_VGA_R), .io_VGA_G(io_VGA_G), .io_VGA_B(io_VGA_B),
    .io_seg0(io_seg0), .io_seg1(io_seg1), .io_seg2(io_seg2), .io_seg3(io_seg3),
    .io_seg4(io_seg4), .io_seg5(io_seg5), .io_seg6(io_seg6), .io_seg7(io_seg7)
  );

  // ---------------- clock / reset ----------------
  always #20 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int n = 0;  // rising edges since reset release

  always @(posedge clock) n <= resetn ? n + 1 : 0;

  task automatic wait_clk(input int k);
    repeat (k) @(posedge clock);
    #2;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int m_brk, m_held, m_code, m_last, m_lastv, m_cnt;

  task automatic model_reset();
    m_brk = 0; m_held = 0; m_code = 0; m_last = 0; m_lastv = 0; m_cnt = 0;
  endtask

  task automatic model_code(input int c);
    m_last = c;
    m_lastv = 1;
    if (c == 'hE0) begin
    end else if (c == 'hF0) begin
      m_brk = 1;
    end else if (m_brk == 1) begin
      m_brk = 0;
      m_held = 0;
    end else if (m_held == 0 || m_code != c) begin
      m_code = c;
      m_held = 1;
      m_cnt = (m_cnt + 1) % 100;
    end
  endtask

  function automatic logic [63:0] exp_disp();
    logic [7:0] s0, s1, s2, s3;
    s0 = m_held  ? seg_tab[m_code % 16] : 8'hFF;
    s1 = m_held  ? seg_tab[m_code / 16] : 8'hFF;
    s2 = m_lastv ? seg_tab[m_last % 16] : 8'hFF;
    s3 = m_lastv ? seg_tab[m_last / 16] : 8'hFF;
    return {8'hFF, 8'hFF, seg_tab[m_cnt / 10], seg_tab[m_cnt % 10], s3, s2, s1, s0};
  endfunction

  // ---------------- scoreboard monitor (display) ----------------
  logic [63:0] exp_q [$];

  always @(negedge clock) begin
    logic [63:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {io_seg7, io_seg6, io_seg5, io_seg4, io_seg3, io_seg2, io_seg1, io_seg0};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL seg t=%0t actual=%h required=%h", $time, a, e);
      end
    end
  end

  // ---------------- VGA / LED monitor ----------------
  always @(negedge clock) begin
    int k, h, v, bar;
    logic hs, vs, bl;
    logic [7:0] r, g, b;
    logic [43:0] e, a;
    k = resetn ? n : 0;
    h = k % 800;
    v = (k / 800) % 525;
    hs = (h >= 96);
    vs = (v >= 2);
    bl = (h >= 144) && (h < 784) && (v >= 35) && (v < 515);
    r = 8'h00; g = 8'h00; b = 8'h00;
    if (bl) begin
      bar = (h - 144) / 80;
      r = ((bar / 4) % 2 == 1) ? 8'hFF : 8'h00;
      g = ((bar / 2) % 2 == 1) ? 8'hFF : 8'h00;
      b = (bar % 2 == 1) ? 8'hFF : 8'h00;
      if (io_sw[0]) begin
        r = ~r; g = ~g; b = ~b;
      end
    end
    e = {io_sw, 1'b0, hs, vs, bl, r, g, b};
    a = {io_ledr, io_VGA_CLK, io_VGA_HSYNC, io_VGA_VSYNC, io_VGA_BLANK_N,
         io_VGA_R, io_VGA_G, io_VGA_B};
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL vga h=%0d v=%0d actual=%h required=%h", h, v, a, e);
    end
  end

  // ---------------- drivers ----------------
  // mode: 0 good, 1 bad parity, 2 bad stop, 3 bad start
  task automatic send_frame(input logic [7:0] d, input int mode);
    logic [10:0] f;
    f = {1'b1, ~^d, d, 1'b0};
    if (mode == 1) f[9] = ~f[9];
    if (mode == 2) f[10] = 1'b0;
    if (mode == 3) f[0] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      ps2d = f[i];
      wait_clk(4);
      ps2c = 1'b0;
      wait_clk(4);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    wait_clk(8);
    if (mode == 0) model_code(int'(d));
    exp_q.push_back(exp_disp());
  endtask

  task automatic apply_reset();
    ps2c = 1'b1;
    ps2d = 1'b1;
    resetn = 1'b0;
    model_reset();
    wait_clk(2);
    exp_q.push_back(exp_disp());
    wait_clk(3);
    resetn = 1'b1;
  endtask

  initial begin
    forever begin
      wait_clk($urandom_range(500, 3000));
      io_sw = 16'($urandom);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] c;
    int sel, mode, guard;
    #2;
    apply_reset();

    send_frame(8'h1C, 0);
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    send_frame(8'h1C, 1);
    send_frame(8'h32, 0);
    send_frame(8'h1C, 2);
    send_frame(8'h1C, 3);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: c = 8'hE0;
        1: c = 8'hF0;
        2: c = 8'h1C;
        3: c = 8'h32;
        default: c = 8'($urandom);
      endcase
      mode = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      send_frame(c, mode);
    end

    // Abort a frame halfway with reset; nothing partial may surface.
    for (int i = 0; i < 5; i++) begin
      ps2d = 1'($urandom);
      wait_clk(4);
      ps2c = 1'b0;
      wait_clk(4);
      ps2c = 1'b1;
    end
    apply_reset();

    for (int i = 0; i < 100; i++) begin
      c = 8'(i + 1);
      send_frame(c, 0);
      send_frame(8'hF0, 0);
      send_frame(c, 0);
    end

    guard = 0;
    while (n < 28144 + 3200 && guard < 40000) begin
      wait_clk(1);
      guard++;
    end
    wait_clk(4);
    compared++;
    if (exp_q.size() != 0 || n < 28144 + 3200) begin
      mismatched++;
      $display("FAIL drain actual_pending=%0d cycles=%0d required_pending=0", exp_q.size(), n);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
